effect_scheduler: RTL and testbench

Sample-rate controller that sequences one audio sample through the effect chain. On each sample tick it pops one sample from the input FIFO, starts both effect engines, waits for both results, and hands the pair to the effect mixer over the mixer's dv/read_done handshake. It sits between the ADC-side input FIFO, the effect modules and `effect_mixer`. It reports dropped ticks and hung engines to the status logic.

---
 rtl/audio_pkg.sv | 17 +
 rtl/sched_watchdog.sv | 24 ++
 rtl/effect_scheduler.sv | 130 +++++++++++++
 tb/tb_effect_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio effect-chain sequencers: state encoding,
// default sample width and drop-counter width.
package audio_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int DROP_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_START,
    ST_WAIT,
    ST_HANDOFF
  } sched_state_t;

endpackage

// File: rtl/sched_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle whose count would reach the limit. A clear in that cycle wins.
module sched_watchdog #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_expire = i_en && !i_clr && (r_cnt == i_limit - W'(1));

endmodule

// File: rtl/effect_scheduler.sv
// Per-sample sequencer: pops one FIFO sample per tick, runs both effect
// engines, collects both results and hands the pair to the mixer.
module effect_scheduler
  import audio_pkg::*;
#(
  parameter int data_width     = DATA_WIDTH,
  parameter int timeout_cycles = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_sample_tick,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  input  logic [data_width-1:0] i_fifo_data,
  output logic                  o_eff_start,
  output logic [data_width-1:0] o_eff_data,
  input  logic                  i_eff0_done,
  input  logic                  i_eff1_done,
  input  logic [data_width-1:0] i_eff0_data,
  input  logic [data_width-1:0] i_eff1_data,
  output logic                  o_dv_to_mix,
  output logic [data_width-1:0] o_data_sw0,
  output logic [data_width-1:0] o_data_sw1,
  input  logic                  i_mix_read_done,
  output logic                  o_busy,
  output logic [DROP_W-1:0]     o_drop_cnt,
  output logic                  o_timeout
);

  localparam int WD_W = $clog2(timeout_cycles + 1);

  sched_state_t r_state;
  logic         r_f0, r_f1;
  logic         w_pair_done, w_wd_clr, w_wd_en, w_expire, w_drop;

  // A flag counts as set in the same cycle its strobe arrives, so both
  // strobes landing together complete the pair immediately.
  assign w_pair_done = (r_state == ST_WAIT) && (r_f0 || i_eff0_done) && (r_f1 || i_eff1_done);
  assign w_wd_clr    = (r_state == ST_START) || w_pair_done;
  assign w_wd_en     = (r_state == ST_WAIT) || (r_state == ST_HANDOFF);
  assign w_drop      = i_sample_tick && ((r_state != ST_IDLE) || i_fifo_empty);

  sched_watchdog #(.W(WD_W)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .i_limit  (WD_W'(timeout_cycles)),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_f0        <= 1'b0;
      r_f1        <= 1'b0;
      o_fifo_rd   <= 1'b0;
      o_eff_start <= 1'b0;
      o_eff_data  <= '0;
      o_dv_to_mix <= 1'b0;
      o_data_sw0  <= '0;
      o_data_sw1  <= '0;
      o_busy      <= 1'b0;
      o_drop_cnt  <= '0;
      o_timeout   <= 1'b0;
    end else begin
      o_fifo_rd   <= 1'b0;
      o_eff_start <= 1'b0;
      o_timeout   <= 1'b0;
      if (w_drop && (o_drop_cnt != '1)) o_drop_cnt <= o_drop_cnt + DROP_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (i_sample_tick && !i_fifo_empty) begin
            r_state   <= ST_READ;
            o_fifo_rd <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        ST_READ: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          o_eff_data  <= i_fifo_data;
          r_f0        <= 1'b0;
          r_f1        <= 1'b0;
          o_eff_start <= 1'b1;
          r_state     <= ST_START;
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_expire) begin
            o_timeout <= 1'b1;
            r_f0      <= 1'b0;
            r_f1      <= 1'b0;
            o_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            // Only the first strobe per engine is kept.
            if (i_eff0_done && !r_f0) begin
              r_f0       <= 1'b1;
              o_data_sw0 <= i_eff0_data;
            end
            if (i_eff1_done && !r_f1) begin
              r_f1       <= 1'b1;
              o_data_sw1 <= i_eff1_data;
            end
            if (w_pair_done) begin
              o_dv_to_mix <= 1'b1;
              r_state     <= ST_HANDOFF;
            end
          end
        end
        ST_HANDOFF: begin
          if (w_expire || i_mix_read_done) begin
            o_timeout   <= w_expire;
            o_dv_to_mix <= 1'b0;
            r_f0        <= 1'b0;
            r_f1        <= 1'b0;
            o_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_effect_scheduler.sv
// Directed bench for effect_scheduler: one instance with the default watchdog
// limit and one with a limit of 8, sharing all inputs.
module tb_effect_scheduler;

  logic        clk, reset, tick, empty, e0d, e1d, rdone;
  logic [15:0] fifo_data, e0v, e1v;

  logic        fifo_rd, eff_start, dv, busy, tmo;
  logic [15:0] eff_data, sw0, sw1;
  logic [7:0]  drop;

  logic        w_fifo_rd, w_eff_start, w_dv, w_busy, w_tmo;
  logic [15:0] w_eff_data, w_sw0, w_sw1;
  logic [7:0]  w_drop;

  int n_cmp = 0;
  int n_err = 0;

  effect_scheduler dut (
    .clk(clk), .reset(reset), .i_sample_tick(tick), .i_fifo_empty(empty),
    .o_fifo_rd(fifo_rd), .i_fifo_data(fifo_data), .o_eff_start(eff_start),
    .o_eff_data(eff_data), .i_eff0_done(e0d), .i_eff1_done(e1d),
    .i_eff0_data(e0v), .i_eff1_data(e1v), .o_dv_to_mix(dv),
    .o_data_sw0(sw0), .o_data_sw1(sw1), .i_mix_read_done(rdone),
    .o_busy(busy), .o_drop_cnt(drop), .o_timeout(tmo)
  );

  effect_scheduler #(.timeout_cycles(8)) dut_wd (
    .clk(clk), .reset(reset), .i_sample_tick(tick), .i_fifo_empty(empty),
    .o_fifo_rd(w_fifo_rd), .i_fifo_data(fifo_data), .o_eff_start(w_eff_start),
    .o_eff_data(w_eff_data), .i_eff0_done(e0d), .i_eff1_done(e1d),
    .i_eff0_data(e0v), .i_eff1_data(e1v), .o_dv_to_mix(w_dv),
    .o_data_sw0(w_sw0), .o_data_sw1(w_sw1), .i_mix_read_done(rdone),
    .o_busy(w_busy), .o_drop_cnt(w_drop), .o_timeout(w_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; tick = 1'b0; e0d = 1'b0; e1d = 1'b0; rdone = 1'b0;
    step; step;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    n_cmp++; if (fifo_rd !== 1'b0)    begin n_err++; $display("FAIL rst_rd: got %b want 0", fifo_rd); end
    n_cmp++; if (eff_start !== 1'b0)  begin n_err++; $display("FAIL rst_start: got %b want 0", eff_start); end
    n_cmp++; if (dv !== 1'b0)         begin n_err++; $display("FAIL rst_dv: got %b want 0", dv); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (tmo !== 1'b0)        begin n_err++; $display("FAIL rst_tmo: got %b want 0", tmo); end
    n_cmp++; if (eff_data !== 16'h0)  begin n_err++; $display("FAIL rst_effdata: got %h want 0", eff_data); end
    n_cmp++; if (sw0 !== 16'h0)       begin n_err++; $display("FAIL rst_sw0: got %h want 0", sw0); end
    n_cmp++; if (sw1 !== 16'h0)       begin n_err++; $display("FAIL rst_sw1: got %h want 0", sw1); end
    n_cmp++; if (drop !== 8'h0)       begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop); end
    n_cmp++; if (w_busy !== 1'b0)     begin n_err++; $display("FAIL rst_wbusy: got %b want 0", w_busy); end
    reset = 1'b1;
  endtask

  task automatic test_nominal;
    fifo_data = 16'h1234; empty = 1'b0; tick = 1'b1;
    step; tick = 1'b0;                                   // cycle k+1
    n_cmp++; if (fifo_rd !== 1'b1)   begin n_err++; $display("FAIL nom_rd: got %b want 1", fifo_rd); end
    n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL nom_busy: got %b want 1", busy); end
    step;                                                // k+2
    n_cmp++; if (fifo_rd !== 1'b0)   begin n_err++; $display("FAIL nom_rd_once: got %b want 0", fifo_rd); end
    n_cmp++; if (eff_start !== 1'b0) begin n_err++; $display("FAIL nom_start_early: got %b want 0", eff_start); end
    step;                                                // k+3
    n_cmp++; if (eff_start !== 1'b1) begin n_err++; $display("FAIL nom_start: got %b want 1", eff_start); end
    n_cmp++; if (eff_data !== 16'h1234) begin n_err++; $display("FAIL nom_effdata: got %h want 1234", eff_data); end
    step;                                                // k+4
    n_cmp++; if (eff_start !== 1'b0) begin n_err++; $display("FAIL nom_start_once: got %b want 0", eff_start); end
    step; step; step;                                    // k+7
    n_cmp++; if (dv !== 1'b0)        begin n_err++; $display("FAIL nom_dv_early: got %b want 0", dv); end
    e0d = 1'b1; e0v = 16'h1000; e1d = 1'b1; e1v = 16'h0800;
    step; e0d = 1'b0; e1d = 1'b0;                        // k+8
    n_cmp++; if (dv !== 1'b1)        begin n_err++; $display("FAIL nom_dv: got %b want 1", dv); end
    n_cmp++; if (sw0 !== 16'h1000)   begin n_err++; $display("FAIL nom_sw0: got %h want 1000", sw0); end
    n_cmp++; if (sw1 !== 16'h0800)   begin n_err++; $display("FAIL nom_sw1: got %h want 0800", sw1); end
    step; step;                                          // k+10
    n_cmp++; if (dv !== 1'b1)        begin n_err++; $display("FAIL nom_dv_hold: got %b want 1", dv); end
    step; rdone = 1'b1;                                  // k+11
    step; rdone = 1'b0;                                  // k+12
    n_cmp++; if (dv !== 1'b0)        begin n_err++; $display("FAIL nom_dv_clr: got %b want 0", dv); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL nom_idle: got %b want 0", busy); end
    n_cmp++; if (drop !== 8'd0)      begin n_err++; $display("FAIL nom_drop: got %0d want 0", drop); end
  endtask

  task automatic test_simultaneous;
    fifo_data = 16'h0042; tick = 1'b1;
    step; tick = 1'b0; step; step; step;                 // k+4, WAIT
    n_cmp++; if (dv !== 1'b0)        begin n_err++; $display("FAIL sim_dv_early: got %b want 0", dv); end
    e0d = 1'b1; e0v = 16'h7FFF; e1d = 1'b1; e1v = 16'h8000;
    step; e0d = 1'b0; e1d = 1'b0;
    n_cmp++; if (dv !== 1'b1)        begin n_err++; $display("FAIL sim_dv: got %b want 1", dv); end
    n_cmp++; if (sw0 !== 16'h7FFF)   begin n_err++; $display("FAIL sim_sw0: got %h want 7fff", sw0); end
    n_cmp++; if (sw1 !== 16'h8000)   begin n_err++; $display("FAIL sim_sw1: got %h want 8000", sw1); end
    rdone = 1'b1;
    step; rdone = 1'b0;                                  // m+1, IDLE
    n_cmp++; if (dv !== 1'b0)        begin n_err++; $display("FAIL sim_dv_clr: got %b want 0", dv); end
  endtask

  // Starts with a tick in the first IDLE cycle after read_done.
  task automatic test_back_to_back;
    fifo_data = 16'h0099; tick = 1'b1;
    step; tick = 1'b0;
    n_cmp++; if (fifo_rd !== 1'b1)   begin n_err++; $display("FAIL b2b_rd: got %b want 1", fifo_rd); end
    step; step;                                          // k+3
    n_cmp++; if (eff_data !== 16'h0099) begin n_err++; $display("FAIL b2b_effdata: got %h want 0099", eff_data); end
    step; e0d = 1'b1; e0v = 16'h0001;                    // k+4
    step; e0v = 16'h0002;                                // k+5, repeated eff0 strobe
    step; e0d = 1'b0; e1d = 1'b1; e1v = 16'h5555;        // k+6
    n_cmp++; if (dv !== 1'b0)        begin n_err++; $display("FAIL rep_dv_early: got %b want 0", dv); end
    step; e1d = 1'b0;
    n_cmp++; if (dv !== 1'b1)        begin n_err++; $display("FAIL rep_dv: got %b want 1", dv); end
    n_cmp++; if (sw0 !== 16'h0001)   begin n_err++; $display("FAIL rep_sw0: got %h want 0001", sw0); end
    n_cmp++; if (sw1 !== 16'h5555)   begin n_err++; $display("FAIL rep_sw1: got %h want 5555", sw1); end
    rdone = 1'b1; tick = 1'b1;                           // tick coincident with read_done
    step; rdone = 1'b0; tick = 1'b0;
    n_cmp++; if (drop !== 8'd1)      begin n_err++; $display("FAIL coinc_drop: got %0d want 1", drop); end
    n_cmp++; if (fifo_rd !== 1'b0)   begin n_err++; $display("FAIL coinc_rd: got %b want 0", fifo_rd); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL coinc_busy: got %b want 0", busy); end
  endtask

  task automatic test_drops;
    int pops;
    do_reset;
    empty = 1'b1; tick = 1'b1;
    step; tick = 1'b0;
    n_cmp++; if (drop !== 8'd1)      begin n_err++; $display("FAIL drp_empty: got %0d want 1", drop); end
    n_cmp++; if (fifo_rd !== 1'b0)   begin n_err++; $display("FAIL drp_empty_rd: got %b want 0", fifo_rd); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL drp_empty_busy: got %b want 0", busy); end
    empty = 1'b0; fifo_data = 16'h0123; tick = 1'b1;
    step; tick = 1'b0; step; step; step;                 // WAIT
    pops = 0;
    for (int i = 0; i < 300; i++) begin
      tick = 1'b1; step; tick = 1'b0;
      pops += int'(fifo_rd);
      step;
      pops += int'(fifo_rd);
      if (i == 199) begin
        n_cmp++; if (drop !== 8'd201) begin n_err++; $display("FAIL drp_mid: got %0d want 201", drop); end
      end
    end
    n_cmp++; if (drop !== 8'd255)    begin n_err++; $display("FAIL drp_sat: got %0d want 255", drop); end
    n_cmp++; if (pops !== 0)         begin n_err++; $display("FAIL drp_pops: got %0d want 0", pops); end
    n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL drp_busy: got %b want 1", busy); end
  endtask

  task automatic test_watchdog;
    int pulses, at;
    do_reset;
    empty = 1'b0; fifo_data = 16'h2222; tick = 1'b1;
    step; tick = 1'b0; step; step; step;                 // k+4
    e0d = 1'b1; e0v = 16'h1111;
    step; e0d = 1'b0;                                    // k+5
    pulses = 0; at = 0;
    for (int c = 5; c <= 20; c++) begin
      if (w_tmo === 1'b1) begin pulses++; at = c; end
      step;
    end
    n_cmp++; if (pulses !== 1)       begin n_err++; $display("FAIL wd_pulses: got %0d want 1", pulses); end
    n_cmp++; if (at !== 12)          begin n_err++; $display("FAIL wd_cycle: got k+%0d want k+12", at); end
    n_cmp++; if (w_busy !== 1'b0)    begin n_err++; $display("FAIL wd_busy: got %b want 0", w_busy); end
    n_cmp++; if (w_dv !== 1'b0)      begin n_err++; $display("FAIL wd_dv: got %b want 0", w_dv); end
    n_cmp++; if (w_sw0 !== 16'h1111) begin n_err++; $display("FAIL wd_sw0_kept: got %h want 1111", w_sw0); end
    fifo_data = 16'h3333; tick = 1'b1;
    step; tick = 1'b0;
    n_cmp++; if (w_fifo_rd !== 1'b1) begin n_err++; $display("FAIL wd_next_rd: got %b want 1", w_fifo_rd); end
    step; step;
    n_cmp++; if (w_eff_start !== 1'b1) begin n_err++; $display("FAIL wd_next_start: got %b want 1", w_eff_start); end
    n_cmp++; if (w_eff_data !== 16'h3333) begin n_err++; $display("FAIL wd_next_data: got %h want 3333", w_eff_data); end
    step; e0d = 1'b1; e0v = 16'h0A0A; e1d = 1'b1; e1v = 16'h0B0B;
    step; e0d = 1'b0; e1d = 1'b0;
    n_cmp++; if (w_dv !== 1'b1)      begin n_err++; $display("FAIL wd_next_dv: got %b want 1", w_dv); end
    n_cmp++; if (w_sw0 !== 16'h0A0A) begin n_err++; $display("FAIL wd_next_sw0: got %h want 0a0a", w_sw0); end
    n_cmp++; if (w_sw1 !== 16'h0B0B) begin n_err++; $display("FAIL wd_next_sw1: got %h want 0b0b", w_sw1); end
    rdone = 1'b1;
    step; rdone = 1'b0;
    n_cmp++; if (w_dv !== 1'b0)      begin n_err++; $display("FAIL wd_next_dvclr: got %b want 0", w_dv); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    empty = 1'b0; fifo_data = 16'h5A5A; tick = 1'b1;
    step; tick = 1'b1;                                   // k+1, this tick is dropped
    step; tick = 1'b0; step; step;                       // k+4
    e0d = 1'b1; e0v = 16'h1357; e1d = 1'b1; e1v = 16'h2468;
    step; e0d = 1'b0; e1d = 1'b0;                        // HANDOFF
    n_cmp++; if (dv !== 1'b1)        begin n_err++; $display("FAIL rm_dv_pre: got %b want 1", dv); end
    n_cmp++; if (drop !== 8'd1)      begin n_err++; $display("FAIL rm_drop_pre: got %0d want 1", drop); end
    reset = 1'b0;
    step;
    n_cmp++; if (dv !== 1'b0)        begin n_err++; $display("FAIL rm_dv: got %b want 0", dv); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_rd !== 1'b0)   begin n_err++; $display("FAIL rm_rd: got %b want 0", fifo_rd); end
    n_cmp++; if (drop !== 8'd0)      begin n_err++; $display("FAIL rm_drop: got %0d want 0", drop); end
    n_cmp++; if (eff_data !== 16'h0) begin n_err++; $display("FAIL rm_effdata: got %h want 0", eff_data); end
    n_cmp++; if (sw0 !== 16'h0)      begin n_err++; $display("FAIL rm_sw0: got %h want 0", sw0); end
    n_cmp++; if (sw1 !== 16'h0)      begin n_err++; $display("FAIL rm_sw1: got %h want 0", sw1); end
    step; reset = 1'b1;
    step;
    n_cmp++; if (dv !== 1'b0)        begin n_err++; $display("FAIL rm_stale_dv: got %b want 0", dv); end
    fifo_data = 16'h4321; tick = 1'b1;
    step; tick = 1'b0;
    n_cmp++; if (fifo_rd !== 1'b1)   begin n_err++; $display("FAIL rm_next_rd: got %b want 1", fifo_rd); end
    step; step;
    n_cmp++; if (eff_start !== 1'b1) begin n_err++; $display("FAIL rm_next_start: got %b want 1", eff_start); end
    n_cmp++; if (eff_data !== 16'h4321) begin n_err++; $display("FAIL rm_next_data: got %h want 4321", eff_data); end
    step;
    n_cmp++; if (dv !== 1'b0)        begin n_err++; $display("FAIL rm_next_dv_early: got %b want 0", dv); end
    e0d = 1'b1; e0v = 16'h0F0F; e1d = 1'b1; e1v = 16'h0E0E;
    step; e0d = 1'b0; e1d = 1'b0;
    n_cmp++; if (dv !== 1'b1)        begin n_err++; $display("FAIL rm_next_dv: got %b want 1", dv); end
    n_cmp++; if (sw0 !== 16'h0F0F)   begin n_err++; $display("FAIL rm_next_sw0: got %h want 0f0f", sw0); end
    rdone = 1'b1;
    step; rdone = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; empty = 1'b1; e0d = 1'b0; e1d = 1'b0; rdone = 1'b0;
    fifo_data = '0; e0v = '0; e1v = '0;
    step; step;
    test_reset;
    step;
    test_nominal;
    test_simultaneous;
    test_back_to_back;
    test_drops;
    test_watchdog;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
